// File: rtl/disparity_align_fuse_pkg.sv
// Shared types and defaults for the disparity alignment/fusion slice.
package disparity_pkg;

  typedef enum logic [1:0] {
    FUSE_PURE = 2'd0,
    FUSE_EDGE = 2'd1,
    FUSE_HOMO = 2'd2,
    FUSE_MIN  = 2'd3
  } fuse_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disparity_align_fuse_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth, flush and count.
module disparity_sync_fifo
  import disparity_pkg::*;
#(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 4096,
  localparam int unsigned AW    = cnt_w(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Accept a push on full only when a pop frees the slot in the same cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap explicitly at DEPTH-1 so any depth works.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/disparity_align_fuse.sv
// Aligns first-pass (pure) disparities with second-pass (edge) disparities
// through a FIFO and fuses each pair. Optional consistency check is enabled
// with the DISP_ALIGN_CONSIST_EN macro.
module disparity_align_fuse
  import disparity_pkg::*;
#(
  parameter  int unsigned DISP_W = 8,
  parameter  int unsigned IMG_W  = DEF_IMG_W,
  parameter  int unsigned IMG_H  = DEF_IMG_H,
  parameter  int unsigned DEPTH  = 4096,
  localparam int unsigned XW     = cnt_w(IMG_W),
  localparam int unsigned YW     = cnt_w(IMG_H)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pure_valid,
  input  logic [DISP_W-1:0] i_pure_disp,
  input  logic              i_homo,
  input  logic              i_edge_valid,
  input  logic [DISP_W-1:0] i_edge_disp,
  input  logic [1:0]        i_mode,
`ifdef DISP_ALIGN_CONSIST_EN
  input  logic [DISP_W-1:0] i_thresh,
`endif
  input  logic              i_clr_err,
  output logic              o_valid,
  output logic [DISP_W-1:0] o_pure_disp,
  output logic [DISP_W-1:0] o_edge_disp,
  output logic [DISP_W-1:0] o_fused_disp,
  output logic              o_homo,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic              o_eof,
  output logic              o_overflow,
  output logic              o_underflow,
`ifdef DISP_ALIGN_CONSIST_EN
  output logic              o_inconsistent,
`endif
  output logic [1:0]        o_state
);

  localparam int unsigned EW = DISP_W + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e            state;
  logic [EW-1:0]     fifo_rdata, pair;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              active, bypass, ovf_now, unf_now, do_push, do_pop;
  logic              pair_ok, at_eof, drain_done, flush;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [DISP_W-1:0] pair_disp, fused;
  logic              pair_homo;
`ifdef DISP_ALIGN_CONSIST_EN
  logic [DISP_W-1:0] diff;
  logic              incons;
`endif

  assign o_state = state;

  disparity_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (flush),
    .push  (do_push),
    .pop   (do_pop),
    .wdata ({i_homo, i_pure_disp}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Classify this cycle's traffic; a push+pop on empty bypasses the FIFO entirely.
  always_comb begin
    active     = (state != ST_ERR);
    bypass     = active && i_pure_valid && i_edge_valid && fifo_empty;
    ovf_now    = active && i_pure_valid && !i_edge_valid && fifo_full;
    unf_now    = active && i_edge_valid && !i_pure_valid && fifo_empty;
    do_push    = active && i_pure_valid && !bypass && !ovf_now;
    do_pop     = active && i_edge_valid && !bypass && !unf_now;
    pair_ok    = bypass || do_pop;
    pair       = bypass ? {i_homo, i_pure_disp} : fifo_rdata;
    at_eof     = (x_cnt == XW'(IMG_W - 1)) && (y_cnt == YW'(IMG_H - 1));
    drain_done = !do_push && (fifo_count == (do_pop ? CW'(1) : CW'(0)));
    flush      = (state == ST_ERR) && i_clr_err;
  end

  // Fuse the aligned pair according to the mode sampled with the edge strobe.
  always_comb begin
    pair_homo = pair[DISP_W];
    pair_disp = pair[DISP_W-1:0];
    case (i_mode)
      FUSE_PURE: fused = pair_disp;
      FUSE_EDGE: fused = i_edge_disp;
      FUSE_HOMO: fused = pair_homo ? i_edge_disp : pair_disp;
      default:   fused = (pair_disp < i_edge_disp) ? pair_disp : i_edge_disp;
    endcase
`ifdef DISP_ALIGN_CONSIST_EN
    diff   = (pair_disp > i_edge_disp) ? pair_disp - i_edge_disp : i_edge_disp - pair_disp;
    incons = (diff > i_thresh);
    if (incons && (i_mode == FUSE_HOMO || i_mode == FUSE_MIN)) fused = '0;
`endif
  end

  // Control FSM, pixel counters, sticky flags and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      o_valid        <= 1'b0;
      o_pure_disp    <= '0;
      o_edge_disp    <= '0;
      o_fused_disp   <= '0;
      o_homo         <= 1'b0;
      o_x            <= '0;
      o_y            <= '0;
      o_eof          <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
`ifdef DISP_ALIGN_CONSIST_EN
      o_inconsistent <= 1'b0;
`endif
    end else begin
      o_valid <= pair_ok;
      o_eof   <= pair_ok && at_eof;
`ifdef DISP_ALIGN_CONSIST_EN
      o_inconsistent <= pair_ok && incons;
`endif
      if (pair_ok) begin
        o_pure_disp  <= pair_disp;
        o_edge_disp  <= i_edge_disp;
        o_fused_disp <= fused;
        o_homo       <= pair_homo;
        o_x          <= x_cnt;
        o_y          <= y_cnt;
        if (x_cnt == XW'(IMG_W - 1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == YW'(IMG_H - 1)) ? '0 : y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
      if (ovf_now) o_overflow  <= 1'b1;
      if (unf_now) o_underflow <= 1'b1;
      // A fresh error outranks a same-cycle clear.
      if (ovf_now || unf_now) begin
        state <= ST_ERR;
      end else if (flush) begin
        o_overflow  <= 1'b0;
        o_underflow <= 1'b0;
        state       <= ST_IDLE;
        x_cnt       <= '0;
        y_cnt       <= '0;
        o_x         <= '0;
        o_y         <= '0;
      end else if (pair_ok && at_eof && drain_done) begin
        state <= ST_IDLE;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pair_ok) begin
        state <= ST_RUN;
      end else if (do_push && state == ST_IDLE) begin
        state <= ST_FILL;
      end
    end
  end

endmodule

// File: tb/tb_disparity_align_fuse.sv
// Directed + randomized bench for disparity_align_fuse against a queue-based
// reference model. Honors DISP_ALIGN_CONSIST_EN when defined.
module tb_disparity_align_fuse;

  logic       clk = 1'b0;
  logic       i_rst_n, i_pure_valid, i_homo, i_edge_valid, i_clr_err;
  logic [7:0] i_pure_disp, i_edge_disp, i_thresh;
  logic [1:0] i_mode;

  // u_def: default geometry; u_sml: 4x2 image; u_ovf: 4x2 image, 8-entry FIFO.
  logic v_d, h_d, eof_d, ovf_d, unf_d, inc_d;
  logic [7:0] pd_d, ed_d, fd_d;
  logic [9:0] x_d;
  logic [8:0] y_d;
  logic [1:0] st_d;
  logic v_s, h_s, eof_s, ovf_s, unf_s, inc_s;
  logic [7:0] pd_s, ed_s, fd_s;
  logic [1:0] x_s;
  logic [0:0] y_s;
  logic [1:0] st_s;
  logic v_o, h_o, eof_o, ovf_o, unf_o, inc_o;
  logic [7:0] pd_o, ed_o, fd_o;
  logic [1:0] x_o;
  logic [0:0] y_o;
  logic [1:0] st_o;

  int unsigned sel;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifndef DISP_ALIGN_CONSIST_EN
  assign inc_d = 1'b0;
  assign inc_s = 1'b0;
  assign inc_o = 1'b0;
`endif

  disparity_align_fuse u_def (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pure_valid(i_pure_valid), .i_pure_disp(i_pure_disp),
    .i_homo(i_homo), .i_edge_valid(i_edge_valid), .i_edge_disp(i_edge_disp), .i_mode(i_mode),
`ifdef DISP_ALIGN_CONSIST_EN
    .i_thresh(i_thresh), .o_inconsistent(inc_d),
`endif
    .i_clr_err(i_clr_err), .o_valid(v_d), .o_pure_disp(pd_d), .o_edge_disp(ed_d),
    .o_fused_disp(fd_d), .o_homo(h_d), .o_x(x_d), .o_y(y_d), .o_eof(eof_d),
    .o_overflow(ovf_d), .o_underflow(unf_d), .o_state(st_d));

  disparity_align_fuse #(.IMG_W(4), .IMG_H(2), .DEPTH(64)) u_sml (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pure_valid(i_pure_valid), .i_pure_disp(i_pure_disp),
    .i_homo(i_homo), .i_edge_valid(i_edge_valid), .i_edge_disp(i_edge_disp), .i_mode(i_mode),
`ifdef DISP_ALIGN_CONSIST_EN
    .i_thresh(i_thresh), .o_inconsistent(inc_s),
`endif
    .i_clr_err(i_clr_err), .o_valid(v_s), .o_pure_disp(pd_s), .o_edge_disp(ed_s),
    .o_fused_disp(fd_s), .o_homo(h_s), .o_x(x_s), .o_y(y_s), .o_eof(eof_s),
    .o_overflow(ovf_s), .o_underflow(unf_s), .o_state(st_s));

  disparity_align_fuse #(.IMG_W(4), .IMG_H(2), .DEPTH(8)) u_ovf (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pure_valid(i_pure_valid), .i_pure_disp(i_pure_disp),
    .i_homo(i_homo), .i_edge_valid(i_edge_valid), .i_edge_disp(i_edge_disp), .i_mode(i_mode),
`ifdef DISP_ALIGN_CONSIST_EN
    .i_thresh(i_thresh), .o_inconsistent(inc_o),
`endif
    .i_clr_err(i_clr_err), .o_valid(v_o), .o_pure_disp(pd_o), .o_edge_disp(ed_o),
    .o_fused_disp(fd_o), .o_homo(h_o), .o_x(x_o), .o_y(y_o), .o_eof(eof_o),
    .o_overflow(ovf_o), .o_underflow(unf_o), .o_state(st_o));

  // Observed outputs of the instance under test.
  logic        ob_v, ob_h, ob_eof, ob_ovf, ob_unf, ob_inc;
  logic [7:0]  ob_pd, ob_ed, ob_fd;
  logic [31:0] ob_x, ob_y;
  logic [1:0]  ob_st;
  always_comb begin
    case (sel)
      0: begin
        ob_v = v_d; ob_h = h_d; ob_eof = eof_d; ob_ovf = ovf_d; ob_unf = unf_d; ob_inc = inc_d;
        ob_pd = pd_d; ob_ed = ed_d; ob_fd = fd_d; ob_x = 32'(x_d); ob_y = 32'(y_d); ob_st = st_d;
      end
      1: begin
        ob_v = v_s; ob_h = h_s; ob_eof = eof_s; ob_ovf = ovf_s; ob_unf = unf_s; ob_inc = inc_s;
        ob_pd = pd_s; ob_ed = ed_s; ob_fd = fd_s; ob_x = 32'(x_s); ob_y = 32'(y_s); ob_st = st_s;
      end
      default: begin
        ob_v = v_o; ob_h = h_o; ob_eof = eof_o; ob_ovf = ovf_o; ob_unf = unf_o; ob_inc = inc_o;
        ob_pd = pd_o; ob_ed = ed_o; ob_fd = fd_o; ob_x = 32'(x_o); ob_y = 32'(y_o); ob_st = st_o;
      end
    endcase
  end

  // Reference model: pending pure samples, state number, flags, pixel index.
  logic [8:0] mq[$];
  int m_st, idx;
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit pv, input logic [7:0] pd, input bit h, input bit ev,
                      input logic [7:0] ed, input logic [1:0] md, input bit clr);
    int w, hh, dep, d;
    bit ex_v, ex_h, ex_eof, ex_inc, in_rst;
    logic [7:0] ex_pd, ex_ed, ex_fd;
    logic [8:0] e;
    int ex_x, ex_y;
    w   = (sel == 0) ? 640 : 4;
    hh  = (sel == 0) ? 480 : 2;
    dep = (sel == 0) ? 4096 : (sel == 1) ? 64 : 8;
    ex_v = 0; ex_h = 0; ex_eof = 0; ex_inc = 0; ex_pd = 0; ex_ed = 0; ex_fd = 0; ex_x = 0; ex_y = 0;
    i_pure_valid = pv; i_pure_disp = pd; i_homo = h; i_edge_valid = ev;
    i_edge_disp = ed; i_mode = md; i_clr_err = clr;
    in_rst = (i_rst_n == 1'b0);
    if (in_rst) begin
      mq.delete(); m_st = 0; m_ovf = 0; m_unf = 0; idx = 0;
    end else if (m_st == 3) begin
      if (clr) begin m_ovf = 0; m_unf = 0; m_st = 0; mq.delete(); idx = 0; end
    end else if (pv && !ev && mq.size() == dep) begin
      m_ovf = 1; m_st = 3;
    end else if (ev && !pv && mq.size() == 0) begin
      m_unf = 1; m_st = 3;
    end else begin
      if (pv) mq.push_back({h, pd});
      if (ev) begin
        e = mq.pop_front();
        ex_v = 1; ex_h = e[8]; ex_pd = e[7:0]; ex_ed = ed;
        ex_x = idx % w; ex_y = (idx / w) % hh;
        ex_eof = ((idx % (w * hh)) == w * hh - 1);
        idx++;
        case (md)
          2'd0: ex_fd = ex_pd;
          2'd1: ex_fd = ed;
          2'd2: ex_fd = ex_h ? ed : ex_pd;
          default: ex_fd = (ex_pd < ed) ? ex_pd : ed;
        endcase
`ifdef DISP_ALIGN_CONSIST_EN
        d = int'(ex_pd) - int'(ed);
        if (d < 0) d = -d;
        ex_inc = (d > int'(i_thresh));
        if (ex_inc && md >= 2) ex_fd = 0;
`else
        d = 0;
`endif
        if (ex_eof && mq.size() == 0) begin m_st = 0; idx = 0; end
        else m_st = 2;
      end else if (pv && m_st == 0) begin
        m_st = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(ob_v), 32'(ex_v));
    chk("state", 32'(ob_st), 32'(m_st));
    chk("overflow", 32'(ob_ovf), 32'(m_ovf));
    chk("underflow", 32'(ob_unf), 32'(m_unf));
    chk("eof", 32'(ob_eof), 32'(ex_eof));
    chk("inconsistent", 32'(ob_inc), 32'(ex_inc));
    if (ex_v || in_rst) begin
      chk("pure", 32'(ob_pd), 32'(ex_pd));
      chk("edge", 32'(ob_ed), 32'(ex_ed));
      chk("fused", 32'(ob_fd), 32'(ex_fd));
      chk("homo", 32'(ob_h), 32'(ex_h));
      chk("x", ob_x, 32'(ex_x));
      chk("y", ob_y, 32'(ex_y));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int unsigned which);
    sel = which;
    i_rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 8'd7, 1, 1, 8'd9, 2'd3, 0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_pure_valid = 0; i_pure_disp = 0; i_homo = 0; i_edge_valid = 0;
    i_edge_disp = 0; i_mode = 0; i_clr_err = 0; i_thresh = 8'd40; sel = 0;
    mq.delete(); m_st = 0; m_ovf = 0; m_unf = 0; idx = 0;

    // Reset state, then 3205 pushes of 0..255 followed by 3205 pops.
    do_reset(0);
    for (int i = 0; i < 3205; i++) step(1, 8'(i % 256), 1'($urandom % 2), 0, 0, 0, 0);
    for (int i = 0; i < 3205; i++)
      step(0, 0, 0, 1, 8'($urandom), 2'($urandom % 4), 0);
    idle();

    // Homo-select alternating, then minimum.
    do_reset(0);
    for (int i = 0; i < 4; i++) step(1, 8'd10, (i % 2) == 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'd20, 2'd2, 0);
    step(1, 8'd10, 1, 0, 0, 0, 0);
    step(1, 8'd10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd20, 2'd3, 0);
    step(0, 0, 0, 1, 8'd20, 2'd3, 0);

    // 8-deep FIFO: fill, legal push+pop on full, overflow, ERR handling.
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 1'($urandom % 2), 0, 0, 0, 0);
    step(1, 8'd99, 1, 1, 8'd5, 2'd0, 0);
    step(1, 8'd77, 0, 0, 0, 0, 0);
    step(1, 8'd1, 0, 1, 8'd2, 2'd1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 8'd3, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 8'd3, 2'd0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 8'd42, 1, 1, 8'd50, 2'd2, 0);
    step(0, 0, 0, 1, 8'd3, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle();

    // 4x2 frame: eof on the 8th output at (3,1), then IDLE; then random traffic.
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1, 8'(i * 3), 1'($urandom % 2), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 8'($urandom), 2'($urandom % 4), 0);
    idle();
    for (int i = 0; i < 400; i++) begin
      bit pv, ev;
      pv = ($urandom % 2) == 1 && mq.size() < 60;
      ev = ($urandom % 2) == 1 && (pv || mq.size() > 0);
      step(pv, 8'($urandom), 1'($urandom % 2), ev, 8'($urandom), 2'($urandom % 4), 0);
    end

    // Mid-frame reset discards buffered samples.
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    step(0, 0, 0, 1, 8'd4, 2'd0, 0);
    i_rst_n = 1'b1;
    step(0, 0, 0, 1, 8'd4, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

`ifdef DISP_ALIGN_CONSIST_EN
    // Consistency threshold.
    do_reset(0);
    i_thresh = 8'd3;
    step(1, 8'd10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd15, 2'd3, 0);
    step(1, 8'd10, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'd15, 2'd0, 0);
    step(1, 8'd10, 1, 1, 8'd12, 2'd3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
